// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: Y86 icodes, status
// codes and the controller FSM state type.
package pipeline_hazard_ctrl_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam int unsigned SBUB = 0;
  localparam int unsigned SAOK = 1;
  localparam int unsigned SHLT = 2;
  localparam int unsigned SADR = 3;
  localparam int unsigned SINS = 4;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    HALT      = 2'd2
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  // Count up on inc_i, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble control for the F/D/E/M/W pipeline registers with
// multi-cycle load-use handling, latched exception halt and saturating
// hazard performance counters.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   RUN       | normal flow, combinational hazards decide stall/bubble
//   LOAD_WAIT | extra load-use stall cycles while the load result is late
//   HALT      | exception reached W; pipe frozen until reset
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  parameter int STAT_W   = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        D_icode_i,
  input  logic [3:0]        d_srcA_i,
  input  logic [3:0]        d_srcB_i,
  input  logic [3:0]        E_icode_i,
  input  logic [3:0]        E_dstM_i,
  input  logic              E_branch_taken_i,
  input  logic              e_Cnd_i,
  input  logic [3:0]        M_icode_i,
  input  logic [STAT_W-1:0] m_stat_i,
  input  logic [STAT_W-1:0] W_stat_i,
  input  logic              h_memory_access_i,
  output logic              F_stall_o,
  output logic              D_stall_o,
  output logic              E_stall_o,
  output logic              M_stall_o,
  output logic              W_stall_o,
  output logic              D_bubble_o,
  output logic              E_bubble_o,
  output logic              M_bubble_o,
  output logic              W_bubble_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  cnt_loaduse_o,
  output logic [CNT_W-1:0]  cnt_mispredict_o,
  output logic [CNT_W-1:0]  cnt_memwait_o
);

  function automatic logic is_exc(input logic [STAT_W-1:0] s);
    return (s == STAT_W'(SADR)) || (s == STAT_W'(SINS)) || (s == STAT_W'(SHLT));
  endfunction

  hz_state_t  state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       load_use, ret, mispredict, exc_w, exc_m;
  logic       inc_lu, inc_mp, inc_mw;

  // Raw hazard detection from the decode/execute/memory stage fields.
  always_comb begin
    load_use   = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
                 ((E_dstM_i == d_srcB_i) ||
                  ((E_dstM_i == d_srcA_i) &&
                   !((D_icode_i == IRMMOVQ) || (D_icode_i == IPUSHQ))));
    ret        = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
    mispredict = (E_icode_i == IJXX) && (e_Cnd_i ^ E_branch_taken_i);
    exc_w      = is_exc(W_stat_i);
    exc_m      = is_exc(m_stat_i);
  end

  // Next-state and stall/bubble outputs; priority HALT > mem > LOAD_WAIT > hazards.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    F_stall_o  = 1'b0;
    D_stall_o  = 1'b0;
    E_stall_o  = 1'b0;
    M_stall_o  = 1'b0;
    W_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_bubble_o = 1'b0;
    M_bubble_o = 1'b0;
    W_bubble_o = 1'b0;
    inc_lu     = 1'b0;
    inc_mp     = 1'b0;
    inc_mw     = 1'b0;
    if (rst_i) begin
      D_bubble_o = 1'b1;
      E_bubble_o = 1'b1;
      M_bubble_o = 1'b1;
      W_bubble_o = 1'b1;
    end else if (state_q == HALT) begin
      F_stall_o  = 1'b1;
      D_stall_o  = 1'b1;
      W_stall_o  = 1'b1;
      E_bubble_o = 1'b1;
      M_bubble_o = 1'b1;
    end else begin
      M_bubble_o = exc_w | exc_m;
      W_stall_o  = exc_w;
      inc_mp     = mispredict & ~h_memory_access_i;
      if (h_memory_access_i) begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_stall_o  = 1'b1;
        M_stall_o  = ~(exc_w | exc_m);
        W_bubble_o = ~exc_w;
        inc_mw     = 1'b1;
      end else if (state_q == LOAD_WAIT) begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_bubble_o = 1'b1;
        inc_lu     = 1'b1;
        wait_d     = wait_q - 3'd1;
        if (wait_q == 3'd1) state_d = RUN;
      end else begin
        // A mispredict squashes the wrong path, so a coincident load-use
        // must neither hold D nor start the extra wait cycles.
        F_stall_o  = load_use | ret;
        D_stall_o  = load_use & ~mispredict;
        E_bubble_o = load_use | mispredict;
        D_bubble_o = mispredict | (ret & ~load_use);
        inc_lu     = load_use & ~mispredict;
        if (load_use && !mispredict && (LOAD_LAT > 1)) begin
          state_d = LOAD_WAIT;
          wait_d  = 3'(LOAD_LAT - 1);
        end
      end
      if (exc_w) state_d = HALT;
    end
  end

  // FSM state and load-wait down-counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign halted_o = (state_q == HALT);

  sat_counter #(.W(CNT_W)) u_cnt_loaduse (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (inc_lu),
    .cnt_o (cnt_loaduse_o)
  );

  sat_counter #(.W(CNT_W)) u_cnt_mispredict (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (inc_mp),
    .cnt_o (cnt_mispredict_o)
  );

  sat_counter #(.W(CNT_W)) u_cnt_memwait (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (inc_mw),
    .cnt_o (cnt_memwait_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LOAD_LAT=1/CNT_W=4 and
// LOAD_LAT=3/CNT_W=16) share stimulus and are compared every cycle against
// a behavioural model that tracks "owed stall cycles" per instance.
module tb_pipeline_hazard_ctrl;

  localparam logic [3:0] T_NOP = 4'h1, T_RMMOV = 4'h4, T_MRMOV = 4'h5, T_OPQ = 4'h6,
                         T_JXX = 4'h7, T_RET = 4'h9, T_PUSH = 4'hA, T_POP = 4'hB;
  localparam logic [2:0] T_SAOK = 3'd1, T_SHLT = 3'd2, T_SADR = 3'd3, T_SINS = 3'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [3:0] D_icode = T_NOP, d_srcA = 4'hF, d_srcB = 4'hF;
  logic [3:0] E_icode = T_NOP, E_dstM = 4'hF, M_icode = T_NOP;
  logic       taken = 1'b0, cnd = 1'b0, mem = 1'b0;
  logic [2:0] m_stat = T_SAOK, W_stat = T_SAOK;

  logic [1:0] f_stall, d_stall, e_stall, m_stall, w_stall;
  logic [1:0] d_bubble, e_bubble, m_bubble, w_bubble, halted;
  logic [3:0]  lu_a, mp_a, mw_a;
  logic [15:0] lu_b, mp_b, mw_b;

  int total = 0;
  int bad = 0;

  pipeline_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(4), .STAT_W(3)) dut_a (
    .clk_i(clk), .rst_i(rst), .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
    .E_icode_i(E_icode), .E_dstM_i(E_dstM), .E_branch_taken_i(taken), .e_Cnd_i(cnd),
    .M_icode_i(M_icode), .m_stat_i(m_stat), .W_stat_i(W_stat), .h_memory_access_i(mem),
    .F_stall_o(f_stall[0]), .D_stall_o(d_stall[0]), .E_stall_o(e_stall[0]),
    .M_stall_o(m_stall[0]), .W_stall_o(w_stall[0]), .D_bubble_o(d_bubble[0]),
    .E_bubble_o(e_bubble[0]), .M_bubble_o(m_bubble[0]), .W_bubble_o(w_bubble[0]),
    .halted_o(halted[0]), .cnt_loaduse_o(lu_a), .cnt_mispredict_o(mp_a), .cnt_memwait_o(mw_a)
  );

  pipeline_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16), .STAT_W(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
    .E_icode_i(E_icode), .E_dstM_i(E_dstM), .E_branch_taken_i(taken), .e_Cnd_i(cnd),
    .M_icode_i(M_icode), .m_stat_i(m_stat), .W_stat_i(W_stat), .h_memory_access_i(mem),
    .F_stall_o(f_stall[1]), .D_stall_o(d_stall[1]), .E_stall_o(e_stall[1]),
    .M_stall_o(m_stall[1]), .W_stall_o(w_stall[1]), .D_bubble_o(d_bubble[1]),
    .E_bubble_o(e_bubble[1]), .M_bubble_o(m_bubble[1]), .W_bubble_o(w_bubble[1]),
    .halted_o(halted[1]), .cnt_loaduse_o(lu_b), .cnt_mispredict_o(mp_b), .cnt_memwait_o(mw_b)
  );

  // ---------------- reference model ----------------
  int lat[2]  = '{1, 3};
  int cmax[2] = '{15, 65535};
  int owed[2] = '{0, 0};
  bit m_halt[2] = '{0, 0};
  int c_lu[2] = '{0, 0};
  int c_mp[2] = '{0, 0};
  int c_mw[2] = '{0, 0};

  function automatic bit m_exc(input logic [2:0] s);
    return (s == T_SADR) || (s == T_SINS) || (s == T_SHLT);
  endfunction

  function automatic bit m_lu();
    bit load_in_e = (E_icode == T_MRMOV) || (E_icode == T_POP);
    bit a_used    = !((D_icode == T_RMMOV) || (D_icode == T_PUSH));
    return load_in_e && ((E_dstM == d_srcB) || (a_used && (E_dstM == d_srcA)));
  endfunction

  function automatic bit m_mp();
    return (E_icode == T_JXX) && (cnd != taken);
  endfunction

  function automatic bit m_ret();
    return (D_icode == T_RET) || (E_icode == T_RET) || (M_icode == T_RET);
  endfunction

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  // {halted, F,D,E,M,W stall, D,E,M,W bubble}
  function automatic logic [9:0] exp_out(input int k);
    bit fs = 0, ds = 0, es = 0, ms = 0, ws = 0, db = 0, eb = 0, mb = 0, wb = 0;
    bit lu = m_lu(), mp = m_mp(), rt = m_ret();
    if (rst) begin
      db = 1; eb = 1; mb = 1; wb = 1;
    end else if (m_halt[k]) begin
      fs = 1; ds = 1; ws = 1; eb = 1; mb = 1;
    end else begin
      mb = m_exc(W_stat) || m_exc(m_stat);
      ws = m_exc(W_stat);
      if (mem) begin
        fs = 1; ds = 1; es = 1; ms = !mb; wb = !ws;
      end else if (owed[k] > 0) begin
        fs = 1; ds = 1; eb = 1;
      end else begin
        fs = lu || rt; ds = lu && !mp; eb = lu || mp; db = mp || (rt && !lu);
      end
    end
    return {m_halt[k], fs, ds, es, ms, ws, db, eb, mb, wb};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        owed[k] = 0; m_halt[k] = 0; c_lu[k] = 0; c_mp[k] = 0; c_mw[k] = 0;
      end else if (!m_halt[k]) begin
        if (mem) c_mw[k] = sat_inc(c_mw[k], cmax[k]);
        else if (owed[k] > 0) begin
          c_lu[k] = sat_inc(c_lu[k], cmax[k]);
          owed[k] = owed[k] - 1;
        end else if (m_lu() && !m_mp()) begin
          c_lu[k] = sat_inc(c_lu[k], cmax[k]);
          owed[k] = lat[k] - 1;
        end
        if (m_mp() && !mem) c_mp[k] = sat_inc(c_mp[k], cmax[k]);
        if (m_exc(W_stat)) m_halt[k] = 1;
      end
    end
  end

  // Cycle-by-cycle scoreboard of controls and counters against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [9:0] g, e;
      int glu, gmp, gmw;
      g = {halted[k], f_stall[k], d_stall[k], e_stall[k], m_stall[k], w_stall[k],
           d_bubble[k], e_bubble[k], m_bubble[k], w_bubble[k]};
      e = exp_out(k);
      glu = (k == 0) ? int'(lu_a) : int'(lu_b);
      gmp = (k == 0) ? int'(mp_a) : int'(mp_b);
      gmw = (k == 0) ? int'(mw_a) : int'(mw_b);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL ctrl_vec dut%0d t=%0t got=%b want=%b", k, $time, g, e);
      end
      total++;
      if (glu != c_lu[k] || gmp != c_mp[k] || gmw != c_mw[k]) begin
        bad++;
        $display("FAIL counters dut%0d t=%0t got=%0d/%0d/%0d want=%0d/%0d/%0d",
                 k, $time, glu, gmp, gmw, c_lu[k], c_mp[k], c_mw[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    D_icode = T_NOP; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = T_NOP; E_dstM = 4'hE;
    M_icode = T_NOP; taken = 0; cnd = 0; mem = 0; m_stat = T_SAOK; W_stat = T_SAOK;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic set_load_use();
    E_icode = T_MRMOV; E_dstM = 4'd3; d_srcB = 4'd3; D_icode = T_OPQ;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1;
    idle();
    @(negedge clk);
    total++;
    if ({d_bubble, e_bubble, m_bubble, w_bubble} !== 8'hFF || {f_stall, d_stall, w_stall} !== 6'h0) begin
      bad++;
      $display("FAIL reset_flush got_bub=%b%b%b%b want all ones", d_bubble, e_bubble, m_bubble, w_bubble);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    total++;
    if (halted !== 2'b00 || lu_a !== 4'd0 || mp_b !== 16'd0 || mw_b !== 16'd0) begin
      bad++;
      $display("FAIL reset_state halted=%b lu_a=%0d mp_b=%0d want 0", halted, lu_a, mp_b);
    end
  endtask

  task automatic test_loaduse();
    int n_a = 0, n_b = 0;
    do_reset();
    set_load_use();
    @(negedge clk);
    total++;
    if (f_stall[0] !== 1'b1 || d_stall[0] !== 1'b1 || e_bubble[0] !== 1'b1) begin
      bad++;
      $display("FAIL loaduse_first got=%b%b%b want=111", f_stall[0], d_stall[0], e_bubble[0]);
    end
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      if (f_stall[0]) n_a++;
      if (f_stall[1]) n_b++;
      @(posedge clk); #1;
      if (i == 0) E_icode = T_NOP;
    end
    @(negedge clk);
    total++;
    if (n_a != 1 || n_b != 3) begin
      bad++;
      $display("FAIL loaduse_len got=%0d/%0d want=1/3", n_a, n_b);
    end
    total++;
    if (lu_a !== 4'd1 || lu_b !== 16'd3) begin
      bad++;
      $display("FAIL loaduse_cnt got=%0d/%0d want=1/3", lu_a, lu_b);
    end
  endtask

  task automatic test_memwait();
    int n_a = 0, n_b = 0;
    do_reset();
    set_load_use();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (f_stall[0]) n_a++;
      if (f_stall[1]) n_b++;
      @(posedge clk); #1;
      if (i == 0) begin E_icode = T_NOP; mem = 1; end
      if (i == 2) mem = 0;
    end
    @(negedge clk);
    total++;
    if (n_a != 3 || n_b != 5) begin
      bad++;
      $display("FAIL memwait_len got=%0d/%0d want=3/5", n_a, n_b);
    end
    total++;
    if (mw_b !== 16'd2 || lu_b !== 16'd3 || mw_a !== 4'd2 || lu_a !== 4'd1) begin
      bad++;
      $display("FAIL memwait_cnt got mw=%0d lu=%0d want mw=2 lu=3", mw_b, lu_b);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    E_icode = T_JXX; cnd = 0; taken = 1; E_dstM = 4'd3; d_srcB = 4'd3; D_icode = T_OPQ;
    @(negedge clk);
    total++;
    if (d_bubble !== 2'b11 || e_bubble !== 2'b11 || d_stall !== 2'b00) begin
      bad++;
      $display("FAIL mispredict_ctl got db=%b eb=%b ds=%b want 11/11/00", d_bubble, e_bubble, d_stall);
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    total++;
    if (f_stall !== 2'b00 || mp_a !== 4'd1 || mp_b !== 16'd1) begin
      bad++;
      $display("FAIL mispredict_after got fs=%b mp=%0d/%0d want 00 1/1", f_stall, mp_a, mp_b);
    end
  endtask

  task automatic test_halt();
    do_reset();
    W_stat = T_SADR;
    mem = 1;
    @(negedge clk);
    total++;
    if (w_stall !== 2'b11 || m_bubble !== 2'b11 || halted !== 2'b00) begin
      bad++;
      $display("FAIL halt_entry got ws=%b mb=%b h=%b want 11/11/00", w_stall, m_bubble, halted);
    end
    @(posedge clk); #1;
    W_stat = T_SAOK;
    for (int i = 0; i < 10; i++) begin
      mem = 1'($urandom_range(0, 1));
      E_icode = T_JXX; taken = 1; cnd = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (f_stall !== 2'b11 || halted !== 2'b11) begin
        bad++;
        $display("FAIL halt_hold cyc=%0d got fs=%b h=%b want 11/11", i, f_stall, halted);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (mw_a !== 4'd1 || mw_b !== 16'd1 || mp_a !== 4'd0 || mp_b !== 16'd0 || lu_b !== 16'd0) begin
      bad++;
      $display("FAIL halt_freeze got mw=%0d/%0d mp=%0d/%0d want 1/1 0/0", mw_a, mw_b, mp_a, mp_b);
    end
    do_reset();
    @(negedge clk);
    total++;
    if (halted !== 2'b00 || mw_a !== 4'd0 || mw_b !== 16'd0) begin
      bad++;
      $display("FAIL halt_clear got h=%b mw=%0d/%0d want 00 0/0", halted, mw_a, mw_b);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    E_icode = T_JXX; taken = 0; cnd = 1;
    for (int i = 0; i < 20; i++) @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    total++;
    if (mp_a !== 4'd15 || mp_b !== 16'd20) begin
      bad++;
      $display("FAIL saturate got=%0d/%0d want=15/20", mp_a, mp_b);
    end
  endtask

  task automatic test_random();
    logic [3:0] e_pool[6];
    e_pool = '{T_NOP, T_MRMOV, T_POP, T_JXX, T_RET, T_OPQ};
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      E_icode = e_pool[$urandom_range(0, 5)];
      D_icode = 4'($urandom_range(0, 11));
      M_icode = ($urandom_range(0, 9) == 0) ? T_RET : T_OPQ;
      d_srcA  = 4'($urandom_range(0, 3));
      d_srcB  = 4'($urandom_range(0, 3));
      E_dstM  = 4'($urandom_range(0, 3));
      taken   = 1'($urandom_range(0, 1));
      cnd     = 1'($urandom_range(0, 1));
      mem     = ($urandom_range(0, 4) == 0);
      m_stat  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 4)) : T_SAOK;
      W_stat  = ($urandom_range(0, 199) == 0) ? 3'($urandom_range(2, 4)) : T_SAOK;
      @(posedge clk); #1;
    end
    idle();
    rst = 0;
    @(negedge clk);
    total++;
    if (int'(lu_b) != c_lu[1] || int'(mp_a) != c_mp[0]) begin
      bad++;
      $display("FAIL random_end got lu_b=%0d mp_a=%0d want %0d/%0d", lu_b, mp_a, c_lu[1], c_mp[0]);
    end
  endtask

  initial begin
    test_reset();
    test_loaduse();
    test_memwait();
    test_mispredict();
    test_halt();
    test_saturation();
    test_random();
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised, stateful successor to the Y86 pipeline hazard unit. It drives the stall and bubble controls for the F/D/E/M/W registers. It extends single-cycle load-use handling to a configurable load latency and latches an exception halt state. It also keeps saturating hazard performance counters. It sits beside the five pipeline registers in the predictor/cache core.

Parameters:
LOAD_LAT, 1, cycles a load result is unavailable after the load leaves E (legal 1..7; 1 = classic one-bubble load-use)
CNT_W, 16, width of each performance counter
STAT_W, 3, width of status codes (encodings from define.v)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
D_icode_i  in  4  icode in D
d_srcA_i  in  4  decode srcA
d_srcB_i  in  4  decode srcB
E_icode_i  in  4  icode in E
E_dstM_i  in  4  dstM in E
E_branch_taken_i  in  1  predictor decision carried in E
e_Cnd_i  in  1  resolved condition
M_icode_i  in  4  icode in M
m_stat_i  in  STAT_W  status leaving M
W_stat_i  in  STAT_W  status in W
h_memory_access_i  in  1  cache miss / memory busy
F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o  out  1 each  hold register
D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o  out  1 each  inject nop
halted_o  out  1  exception halt latched
cnt_loaduse_o  out  CNT_W  load-use stall cycles
cnt_mispredict_o  out  CNT_W  mispredicts resolved
cnt_memwait_o  out  CNT_W  memory-wait cycles

Behaviour:
- Clock is clk_i. Reset is synchronous and active-high on rst_i, sampled at the rising edge.
- Reset: state=RUN, wait_cnt=0, all counters=0, halted_o=0.
- While rst_i=1: all *_stall_o=0 and D/E/M/W_bubble_o=1, so the pipe flushes.
- Hazard terms (combinational):
  - load_use = E_icode in {IMRMOVQ, IPOPQ} and (E_dstM==d_srcB, or E_dstM==d_srcA with D_icode not in {IRMMOVQ, IPUSHQ}).
  - ret = IRET in D, E or M.
  - mispredict = E_icode==IJXX and (e_Cnd xor E_branch_taken).
  - exc(s) = s in {SADR, SINS, SHLT}.
- FSM states: RUN, LOAD_WAIT, HALT. Output priority: HALT > mem > LOAD_WAIT > combinational hazards.
- HALT: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, all others 0. The unit stays in HALT until reset and counters freeze.
- Any state except HALT:
  - exc(W_stat) gives W_stall=1 and M_bubble=1, and the next state is HALT (halted_o=1 from the following cycle).
  - exc(m_stat) alone gives M_bubble=1.
- mem = h_memory_access_i (not in HALT):
  - F/D/E stall=1, M_stall=~M_bubble, W_bubble=~W_stall.
  - D and E bubbles are 0.
  - The FSM holds and wait_cnt holds. cnt_memwait increments.
- RUN, no mem:
  - F_stall = load_use|ret; D_stall = load_use.
  - E_bubble = load_use|mispredict; D_bubble = mispredict | (ret & ~load_use).
  - On load_use with LOAD_LAT>1: wait_cnt <= LOAD_LAT-1 and the next state is LOAD_WAIT.
- LOAD_WAIT, no mem:
  - F_stall=D_stall=1, E_bubble=1; other hazard outputs 0.
  - wait_cnt decrements; when wait_cnt reaches 1 the next state is RUN.
- Counters:
  - cnt_loaduse increments each cycle a load-use stall is applied (RUN load_use or LOAD_WAIT) and mem=0.
  - cnt_mispredict increments when mispredict=1 and mem=0.
  - All counters saturate at 2^CNT_W-1 (no wrap).
- Simultaneous events:
  - mispredict and load_use in the same cycle: mispredict wins for D (D_bubble=1, D_stall=0). E_bubble=1 and no LOAD_WAIT entry, because the wrong path is squashed.
  - exc(W) together with mem: exception terms apply, and the HALT transition still occurs.
  - rst_i during LOAD_WAIT or HALT returns to RUN next cycle.
- Latency: stall/bubble outputs are combinational from inputs and state. State, counters and halted_o are registered, one cycle.

Decomposition:
- Icode and status constants stay in define.v.
- Add the FSM state localparams (RUN=2'd0, LOAD_WAIT=2'd1, HALT=2'd2) to define.v as shared constants.
- One natural sub-module: sat_counter (parameter W; inputs clk_i, rst_i, inc_i; output cnt_o). It is instantiated three times.

Test Plan:
- LOAD_LAT=1: E_icode=5, E_dstM=3, d_srcB=3, D_icode=6 -> one cycle F_stall=D_stall=E_bubble=1; cnt_loaduse=1; state stays RUN.
- LOAD_LAT=3, same stimulus, then E_icode=1 -> stall/bubble for 3 consecutive cycles, then normal flow; cnt_loaduse=3.
- LOAD_LAT=3, h_memory_access_i=1 for 2 cycles inserted during LOAD_WAIT -> total stalled cycles 5; cnt_memwait=2; cnt_loaduse=3.
- E_icode=7, e_Cnd=0, E_branch_taken=1 with a load_use pattern present -> D_bubble=1, E_bubble=1, D_stall=0, no LOAD_WAIT; cnt_mispredict=1.
- W_stat=3 (SADR) -> same cycle W_stall=1, M_bubble=1; halted_o=1 next cycle; F_stall=1 held 10 cycles; counters frozen; rst_i=1 one cycle clears halted_o and counters.
- CNT_W=4, 20 mispredicts -> cnt_mispredict saturates at 15.
